// File: rtl/gcbp_subimage_sequencer_if.sv
// Line/frame event inputs and sub-image row outputs of the GCBP vertical sub-image sequencer.
// The master side is the line/frame detector; the slave side is the sequencer.
interface gcbp_subimage_sequencer_if #(
    parameter int C_LINE_CNT_BITS = 10,
    parameter int C_LINE_IDX_BITS = 6,
    parameter int C_ADDR_BITS     = 9
);
    logic [C_LINE_CNT_BITS-1:0] i_line_cnt;
    logic                       i_new_line;
    logic                       i_new_frame;
    logic                       i_field_0;
    logic                       i_field0_only;

    logic                       o_row_active;
    logic [2:0]                 o_row_idx;
    logic [C_LINE_IDX_BITS-1:0] o_line_idx;
    logic [C_ADDR_BITS-1:0]     o_bram_addr;
    logic                       o_row_done;
    logic                       o_frame_done;
    logic                       o_err_short_frame;
    logic [1:0]                 o_next_frame_loc;
    logic [1:0]                 o_curr_frame_loc;
    logic [1:0]                 o_prev_frame_loc;

    modport master (
        output i_line_cnt, i_new_line, i_new_frame, i_field_0, i_field0_only,
        input  o_row_active, o_row_idx, o_line_idx, o_bram_addr, o_row_done,
               o_frame_done, o_err_short_frame, o_next_frame_loc, o_curr_frame_loc,
               o_prev_frame_loc
    );

    modport slave (
        input  i_line_cnt, i_new_line, i_new_frame, i_field_0, i_field0_only,
        output o_row_active, o_row_idx, o_line_idx, o_bram_addr, o_row_done,
               o_frame_done, o_err_short_frame, o_next_frame_loc, o_curr_frame_loc,
               o_prev_frame_loc
    );
endinterface

// File: rtl/gcbp_subimage_sequencer.sv
// Vertical sub-image row sequencer: maps incoming lines to (row, line-in-row), produces the
// triple-buffered BRAM write address and rotates the next/curr/prev frame slots per complete frame.
module gcbp_subimage_sequencer #(
    parameter int C_NUM_ROWS      = 4,
    parameter int C_ROW_HEIGHT    = 64,
    parameter int C_EDGE_GAP      = 46,
    parameter int C_INTER_GAP     = 44,
    parameter int C_LINE_CNT_BITS = 10,
    parameter int C_ADDR_BITS     = 9
) (
    input  logic                            i_clk,
    input  logic                            i_resetn,
    gcbp_subimage_sequencer_if.slave        io_seq
);
    localparam int C_LINE_IDX_BITS = (C_ROW_HEIGHT > 1) ? $clog2(C_ROW_HEIGHT) : 1;
    localparam int C_START_BITS    = C_LINE_CNT_BITS + 2;
    localparam logic [C_START_BITS-1:0]    C_START0    = C_START_BITS'(C_EDGE_GAP);
    localparam logic [C_START_BITS-1:0]    C_PITCH     = C_START_BITS'(C_ROW_HEIGHT + C_INTER_GAP);
    localparam logic [C_LINE_IDX_BITS-1:0] C_LAST_LINE = C_LINE_IDX_BITS'(C_ROW_HEIGHT - 1);
    localparam logic [2:0]                 C_LAST_ROW  = 3'(C_NUM_ROWS - 1);

    if (2*C_EDGE_GAP + C_NUM_ROWS*C_ROW_HEIGHT + (C_NUM_ROWS-1)*C_INTER_GAP > 2**C_LINE_CNT_BITS)
    begin : g_bad_geometry
        $error("gcbp_subimage_sequencer: row geometry does not fit in the line counter range");
    end

    typedef enum logic [1:0] {S_WAIT_FRAME, S_GAP, S_CAPTURE, S_FRAME_END} state_t;

    state_t                     r_state, w_state_nxt;
    logic [2:0]                 r_row_idx, w_row_idx_nxt;
    logic [C_LINE_IDX_BITS-1:0] r_line_idx, w_line_idx_nxt;
    logic                       r_row_active, w_row_active_nxt;
    logic [C_START_BITS-1:0]    r_row_start, w_row_start_nxt;
    logic                       r_row_done, w_row_done_nxt;
    logic                       r_frame_done, w_frame_done_nxt;
    logic                       r_err, w_err_nxt;
    logic [1:0]                 r_next_loc, w_next_loc_nxt;
    logic [1:0]                 r_curr_loc, w_curr_loc_nxt;
    logic [1:0]                 r_prev_loc, w_prev_loc_nxt;
    logic [C_ADDR_BITS-1:0]     r_bram_addr, w_bram_addr_nxt;

    logic                       w_line_evt;
    logic [C_START_BITS-1:0]    w_line;

    function automatic logic [C_ADDR_BITS-1:0] f_addr(input logic [1:0] loc,
                                                      input logic [C_LINE_IDX_BITS-1:0] idx);
        return C_ADDR_BITS'(int'(loc) * C_ROW_HEIGHT + int'(idx));
    endfunction

    // Odd-field lines are invisible when capturing field 0 only.
    assign w_line_evt = io_seq.i_new_line & ~(io_seq.i_field0_only & ~io_seq.i_field_0);
    assign w_line     = C_START_BITS'(io_seq.i_line_cnt);

    always_comb begin
        w_state_nxt      = r_state;
        w_row_idx_nxt    = r_row_idx;
        w_line_idx_nxt   = r_line_idx;
        w_row_active_nxt = r_row_active;
        w_row_start_nxt  = r_row_start;
        w_row_done_nxt   = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_err_nxt        = 1'b0;
        w_next_loc_nxt   = r_next_loc;
        w_curr_loc_nxt   = r_curr_loc;
        w_prev_loc_nxt   = r_prev_loc;
        w_bram_addr_nxt  = r_bram_addr;

        case (r_state)
            S_WAIT_FRAME: begin
                if (io_seq.i_new_frame) begin
                    w_state_nxt     = S_GAP;
                    w_row_idx_nxt   = '0;
                    w_row_start_nxt = C_START0;
                end
            end
            S_GAP: begin
                // A new frame always wins over a coincident line event.
                if (io_seq.i_new_frame) begin
                    w_err_nxt       = 1'b1;
                    w_row_idx_nxt   = '0;
                    w_row_start_nxt = C_START0;
                end else if (w_line_evt) begin
                    if (w_line == r_row_start) begin
                        w_state_nxt      = S_CAPTURE;
                        w_line_idx_nxt   = '0;
                        w_row_active_nxt = 1'b1;
                        w_bram_addr_nxt  = f_addr(r_next_loc, '0);
                    end else if (w_line > r_row_start) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_WAIT_FRAME;
                    end
                end
            end
            S_CAPTURE: begin
                if (io_seq.i_new_frame) begin
                    w_err_nxt        = 1'b1;
                    w_row_active_nxt = 1'b0;
                    w_row_idx_nxt    = '0;
                    w_row_start_nxt  = C_START0;
                    w_state_nxt      = S_GAP;
                end else if (w_line_evt) begin
                    if (r_line_idx == C_LAST_LINE) begin
                        w_row_done_nxt   = 1'b1;
                        w_row_active_nxt = 1'b0;
                        if (r_row_idx == C_LAST_ROW) begin
                            w_frame_done_nxt = 1'b1;
                            w_state_nxt      = S_FRAME_END;
                        end else begin
                            w_row_idx_nxt   = r_row_idx + 3'd1;
                            w_row_start_nxt = r_row_start + C_PITCH;
                            w_state_nxt     = S_GAP;
                        end
                    end else begin
                        w_line_idx_nxt  = r_line_idx + C_LINE_IDX_BITS'(1);
                        w_bram_addr_nxt = f_addr(r_next_loc, r_line_idx + C_LINE_IDX_BITS'(1));
                    end
                end
            end
            S_FRAME_END: begin
                if (io_seq.i_new_frame) begin
                    w_prev_loc_nxt  = r_curr_loc;
                    w_curr_loc_nxt  = r_next_loc;
                    w_next_loc_nxt  = r_prev_loc;
                    w_row_idx_nxt   = '0;
                    w_row_start_nxt = C_START0;
                    w_state_nxt     = S_GAP;
                end
            end
            default: w_state_nxt = S_WAIT_FRAME;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state      <= S_WAIT_FRAME;
            r_row_idx    <= '0;
            r_line_idx   <= '0;
            r_row_active <= 1'b0;
            r_row_start  <= C_START0;
            r_row_done   <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_next_loc   <= 2'd0;
            r_curr_loc   <= 2'd1;
            r_prev_loc   <= 2'd2;
        end else begin
            r_state      <= w_state_nxt;
            r_row_idx    <= w_row_idx_nxt;
            r_line_idx   <= w_line_idx_nxt;
            r_row_active <= w_row_active_nxt;
            r_row_start  <= w_row_start_nxt;
            r_row_done   <= w_row_done_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_err        <= w_err_nxt;
            r_next_loc   <= w_next_loc_nxt;
            r_curr_loc   <= w_curr_loc_nxt;
            r_prev_loc   <= w_prev_loc_nxt;
        end
    end

    // The address is only meaningful while a row is active, so it carries no reset.
    always_ff @(posedge i_clk) begin
        r_bram_addr <= w_bram_addr_nxt;
    end

    assign io_seq.o_row_active      = r_row_active;
    assign io_seq.o_row_idx         = r_row_idx;
    assign io_seq.o_line_idx        = r_line_idx;
    assign io_seq.o_bram_addr       = r_bram_addr;
    assign io_seq.o_row_done        = r_row_done;
    assign io_seq.o_frame_done      = r_frame_done;
    assign io_seq.o_err_short_frame = r_err;
    assign io_seq.o_next_frame_loc  = r_next_loc;
    assign io_seq.o_curr_frame_loc  = r_curr_loc;
    assign io_seq.o_prev_frame_loc  = r_prev_loc;
endmodule

// File: tb/tb_gcbp_subimage_sequencer.sv
// Self-checking bench for gcbp_subimage_sequencer: random line spacing and field patterns
// compared every cycle against a frame/row counting model of the sub-image geometry.
module tb_gcbp_subimage_sequencer;
    localparam int N = 4;
    localparam int H = 64;
    localparam int E = 46;
    localparam int G = 44;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    gcbp_subimage_sequencer_if #(.C_LINE_CNT_BITS(10), .C_LINE_IDX_BITS(6), .C_ADDR_BITS(9)) bus ();

    gcbp_subimage_sequencer #(
        .C_NUM_ROWS(N), .C_ROW_HEIGHT(H), .C_EDGE_GAP(E), .C_INTER_GAP(G),
        .C_LINE_CNT_BITS(10), .C_ADDR_BITS(9)
    ) dut (
        .i_clk    (clk),
        .i_resetn (resetn),
        .io_seq   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cur     = 0;

    // Model: mode 0 = no frame armed, 1 = capturing a frame, 2 = all rows captured.
    int   m_mode, m_row, m_n;
    int   m_loc[3];
    logic e_active, e_done, e_fdone, e_err;
    int   e_row, e_lidx, e_addr;

    logic f0 = 1'b1, f0only = 1'b0, rnd_f0 = 1'b0;
    int   cnt_rd, cnt_fd, cnt_err, cnt_rise, first_addr;
    logic prev_act = 1'b0;

    task automatic model_reset();
        m_mode = 0; m_row = 0; m_n = 0;
        m_loc[0] = 0; m_loc[1] = 1; m_loc[2] = 2;
        e_active = 0; e_done = 0; e_fdone = 0; e_err = 0;
        e_row = 0; e_lidx = 0;
    endtask

    task automatic model_step(input bit nl, input bit nf, input int l);
        int  r_start, t;
        bit  lev;
        e_done = 0; e_fdone = 0; e_err = 0;
        lev = nl && !(f0only && !f0);
        if (nf) begin
            if (m_mode == 1) e_err = 1;
            else if (m_mode == 2) begin
                t = m_loc[2]; m_loc[2] = m_loc[1]; m_loc[1] = m_loc[0]; m_loc[0] = t;
            end
            m_mode = 1; m_row = 0; m_n = 0; e_active = 0; e_row = 0;
        end else if (lev && m_mode == 1) begin
            r_start = E + m_row * (H + G);
            if (m_n == 0) begin
                if (l == r_start) begin
                    m_n = 1; e_active = 1; e_lidx = 0; e_addr = m_loc[0] * H;
                end else if (l > r_start) begin
                    e_err = 1; m_mode = 0;
                end
            end else if (m_n == H) begin
                e_done = 1; e_active = 0; m_n = 0;
                if (m_row == N - 1) begin
                    e_fdone = 1; m_mode = 2;
                end else begin
                    m_row++; e_row = m_row;
                end
            end else begin
                e_lidx = m_n; e_addr = m_loc[0] * H + m_n; m_n++;
            end
        end
    endtask

    function automatic logic [18:0] expv();
        return {e_active, 3'(e_row), 6'(e_lidx), e_done, e_fdone, e_err,
                2'(m_loc[0]), 2'(m_loc[1]), 2'(m_loc[2])};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.o_row_active, bus.o_row_idx, bus.o_line_idx, bus.o_row_done,
                bus.o_frame_done, bus.o_err_short_frame, bus.o_next_frame_loc,
                bus.o_curr_frame_loc, bus.o_prev_frame_loc};
    endfunction

    task automatic clear_counts();
        cnt_rd = 0; cnt_fd = 0; cnt_err = 0; cnt_rise = 0; first_addr = -1;
    endtask

    task automatic tick(input bit nl, input bit nf, input bit rstn, input int l);
        bus.i_new_line    = nl;
        bus.i_new_frame   = nf;
        bus.i_line_cnt    = 10'(l);
        bus.i_field_0     = f0;
        bus.i_field0_only = f0only;
        resetn            = rstn;
        if (!rstn) model_reset();
        else model_step(nl, nf, l);
        @(posedge clk);
        #1;
        cyc++;
        bus.i_new_line  = 1'b0;
        bus.i_new_frame = 1'b0;
        resetn          = 1'b1;
        if (bus.o_row_done) cnt_rd++;
        if (bus.o_frame_done) cnt_fd++;
        if (bus.o_err_short_frame) cnt_err++;
        if (bus.o_row_active && !prev_act) begin
            cnt_rise++;
            if (first_addr < 0) first_addr = int'(bus.o_bram_addr);
        end
        prev_act = bus.o_row_active;
    endtask

    task automatic run_lines(input string tag, input int first, input int last);
        int l;
        bit ev;
        l = first;
        while (l <= last) begin
            ev = ($urandom_range(0, 3) != 0);
            if (ev && rnd_f0) f0 = 1'($urandom_range(0, 1));
            if (ev) cur = l;
            tick(ev, 1'b0, 1'b1, cur);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL %s cyc=%0d line=%0d got=%h want=%h", tag, cyc, cur, obs(), expv());
            end
            if (e_active) begin
                n_tests++;
                if (bus.o_bram_addr !== 9'(e_addr)) begin
                    n_fail++;
                    $display("FAIL %s_addr cyc=%0d line=%0d got=%0d want=%0d",
                             tag, cyc, cur, bus.o_bram_addr, e_addr);
                end
            end
            if (ev) l++;
        end
    endtask

    task automatic pulse_frame(input string tag, input bit nl, input int l);
        cur = l;
        tick(nl, 1'b1, 1'b1, l);
        n_tests++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL %s_frame cyc=%0d got=%h want=%h", tag, cyc, obs(), expv());
        end
    endtask

    task automatic do_reset(input string tag, input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0, cur);
        n_tests++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL %s_rst cyc=%0d got=%h want=%h", tag, cyc, obs(), expv());
        end
    endtask

    task automatic test_reset();
        do_reset("reset", 2);
        n_tests++;
        if (obs() !== 19'h00006) begin
            n_fail++;
            $display("FAIL reset_state got=%h want=%h", obs(), 19'h00006);
        end
    endtask

    task automatic test_full_frame();
        clear_counts();
        pulse_frame("t1", 1'b0, 0);
        run_lines("t1", 0, 479);
        n_tests++;
        if (cnt_rd !== 4 || cnt_fd !== 1 || cnt_rise !== 4 || cnt_err !== 0) begin
            n_fail++;
            $display("FAIL t1_counts got rd=%0d fd=%0d rise=%0d err=%0d want 4 1 4 0",
                     cnt_rd, cnt_fd, cnt_rise, cnt_err);
        end
        n_tests++;
        if (first_addr !== 0) begin
            n_fail++;
            $display("FAIL t1_first_addr got=%0d want=0", first_addr);
        end
    endtask

    task automatic test_rotation();
        pulse_frame("t2a", 1'b0, 0);
        n_tests++;
        if ({bus.o_next_frame_loc, bus.o_curr_frame_loc, bus.o_prev_frame_loc} !== 6'b10_00_01) begin
            n_fail++;
            $display("FAIL t2_locs1 got=%b want=100001",
                     {bus.o_next_frame_loc, bus.o_curr_frame_loc, bus.o_prev_frame_loc});
        end
        clear_counts();
        run_lines("t2a", 0, 479);
        n_tests++;
        if (first_addr !== 128) begin
            n_fail++;
            $display("FAIL t2_first_addr got=%0d want=128", first_addr);
        end
        pulse_frame("t2b", 1'b0, 0);
        n_tests++;
        if ({bus.o_next_frame_loc, bus.o_curr_frame_loc, bus.o_prev_frame_loc} !== 6'b01_10_00) begin
            n_fail++;
            $display("FAIL t2_locs2 got=%b want=011000",
                     {bus.o_next_frame_loc, bus.o_curr_frame_loc, bus.o_prev_frame_loc});
        end
        clear_counts();
        run_lines("t2b", 0, 479);
        n_tests++;
        if (cnt_fd !== 1 || first_addr !== 64) begin
            n_fail++;
            $display("FAIL t2_frame3 got fd=%0d addr=%0d want 1 64", cnt_fd, first_addr);
        end
    endtask

    task automatic test_short_frame();
        do_reset("t3", 1);
        pulse_frame("t3", 1'b0, 0);
        run_lines("t3", 0, 200);
        pulse_frame("t3abort", 1'b0, 0);
        n_tests++;
        if (bus.o_err_short_frame !== 1'b1 ||
            {bus.o_next_frame_loc, bus.o_curr_frame_loc, bus.o_prev_frame_loc} !== 6'b00_01_10) begin
            n_fail++;
            $display("FAIL t3_abort got err=%b locs=%b want 1 000110", bus.o_err_short_frame,
                     {bus.o_next_frame_loc, bus.o_curr_frame_loc, bus.o_prev_frame_loc});
        end
        clear_counts();
        run_lines("t3", 0, 60);
        n_tests++;
        if (first_addr !== 0) begin
            n_fail++;
            $display("FAIL t3_rewrite_addr got=%0d want=0", first_addr);
        end
    endtask

    task automatic test_field_mode();
        do_reset("t4", 1);
        pulse_frame("t4", 1'b0, 0);
        f0only = 1'b1;
        f0 = 1'b1;
        run_lines("t4", 0, 45);
        f0 = 1'b0;
        run_lines("t4", 46, 50);
        f0 = 1'b1;
        clear_counts();
        run_lines("t4", 51, 200);
        n_tests++;
        if (cnt_err !== 1 || cnt_rise !== 0) begin
            n_fail++;
            $display("FAIL t4_missed_start got err=%0d rise=%0d want 1 0", cnt_err, cnt_rise);
        end
        f0only = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset("t5", 1);
        pulse_frame("t5", 1'b0, 0);
        run_lines("t5", 0, 100);
        do_reset("t5", 1);
        n_tests++;
        if (obs() !== 19'h00006) begin
            n_fail++;
            $display("FAIL t5_reset_state got=%h want=%h", obs(), 19'h00006);
        end
        clear_counts();
        run_lines("t5", 101, 479);
        n_tests++;
        if (cnt_rise !== 0 || cnt_rd !== 0 || cnt_err !== 0) begin
            n_fail++;
            $display("FAIL t5_idle got rise=%0d rd=%0d err=%0d want 0 0 0", cnt_rise, cnt_rd, cnt_err);
        end
    endtask

    task automatic test_back_to_back();
        do_reset("t6", 1);
        pulse_frame("t6", 1'b0, 0);
        run_lines("t6", 0, 479);
        pulse_frame("t6coll", 1'b1, 0);
        n_tests++;
        if ({bus.o_next_frame_loc, bus.o_curr_frame_loc, bus.o_prev_frame_loc} !== 6'b10_00_01 ||
            bus.o_err_short_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_rotate got locs=%b err=%b want 100001 0",
                     {bus.o_next_frame_loc, bus.o_curr_frame_loc, bus.o_prev_frame_loc},
                     bus.o_err_short_frame);
        end
        clear_counts();
        run_lines("t6", 1, 60);
        n_tests++;
        if (first_addr !== 128) begin
            n_fail++;
            $display("FAIL t6_row0_addr got=%0d want=128", first_addr);
        end
    endtask

    task automatic test_random();
        int last;
        do_reset("rnd", 1);
        for (int k = 0; k < 8; k++) begin
            f0only = ($urandom_range(0, 3) == 0);
            rnd_f0 = 1'b1;
            pulse_frame("rnd", 1'($urandom_range(0, 1)), 0);
            last = $urandom_range(40, 479);
            run_lines("rnd", 0, last);
        end
        rnd_f0 = 1'b0;
        f0 = 1'b1;
        f0only = 1'b0;
    endtask

    initial begin
        bus.i_line_cnt    = '0;
        bus.i_new_line    = 1'b0;
        bus.i_new_frame   = 1'b0;
        bus.i_field_0     = 1'b1;
        bus.i_field0_only = 1'b0;
        model_reset();
        clear_counts();
        #2;
        test_reset();
        test_full_frame();
        test_rotation();
        test_short_frame();
        test_field_mode();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
